// File: rtl/hazard_pkg.sv
// hazard_pkg: types and constants shared by the pipeline hazard controller,
// its optional performance counters and the pipeline registers.
//   state_e    : controller state (RUN, MC_BUSY)
//   REG_ADDR_W : default register index width
//   X0         : index of the hard-wired zero register
//   NOP_INSN   : instruction word loaded into a stage register on flush/bubble
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

    localparam int          REG_ADDR_W = 5;
    localparam logic [4:0]  X0         = 5'd0;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: three saturating event counters for the hazard
// controller. Only instantiated when HAZARD_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears counts)
//   stall_i             a load-use stall was acted on this cycle
//   flush_i             IF/ID was flushed this cycle
//   mc_i                controller is in MC_BUSY this cycle
//   perf_stall_cycles   count of stall_i cycles
//   perf_flushes        count of flush_i cycles
//   perf_mc_cycles      count of mc_i cycles
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             mc_i,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flushes,
    output logic [CNT_W-1:0] perf_mc_cycles
);

    logic [CNT_W-1:0] stall_q, flush_q, mc_q;

    // Each counter sticks at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
            mc_q    <= '0;
        end else begin
            if (stall_i && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_i && (flush_q != '1)) flush_q <= flush_q + 1'b1;
            if (mc_i    && (mc_q    != '1)) mc_q    <= mc_q    + 1'b1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flushes      = flush_q;
    assign perf_mc_cycles    = mc_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencing for a 5-stage pipeline.
//   - one-bubble stall on a load-use hazard forwarding cannot cover
//   - flush of the wrong-path instruction on a taken branch
//   - pipeline freeze while the multi-cycle EX unit runs, with a watchdog
// Optional feature macro: HAZARD_PERF_CNT_EN (adds saturating perf counters;
// when undefined the perf_* ports are tied to 0).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs*    source operands of the ID instruction
//   id_ex_rd, id_ex_memRead       destination / load flag of the EX instruction
//   ex_is_mc, mc_done             multi-cycle unit request and completion pulse
//   ex_branch_taken               EX resolved a taken branch/jump
//   pc_write, if_id_write         front-end load enables
//   if_id_flush, id_ex_bubble     NOP insertion into IF/ID, ID/EX
//   id_ex_write, ex_mem_bubble    ID/EX load enable, NOP insertion into EX/MEM
//   mc_start                      start pulse to the multi-cycle unit
//   mc_timeout                    sticky watchdog error flag
//   busy                          controller is in MC_BUSY
//   perf_*                        performance counters
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_memRead,
    input  logic                  ex_is_mc,
    input  logic                  ex_branch_taken,
    input  logic                  mc_done,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mc_start,
    output logic                  mc_timeout,
    output logic                  busy,
    output logic [CNT_W-1:0]      perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_flushes,
    output logic [CNT_W-1:0]      perf_mc_cycles
);

    import hazard_pkg::*;

    // Watchdog counts 0..MC_TIMEOUT-1; MC_TIMEOUT never exceeds 255.
    localparam logic [7:0] WD_LAST = 8'(MC_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic       timeout_q, timeout_d;
    logic       load_use;

    // A load into x0 is discarded, so it can never create a dependency.
    assign load_use = id_ex_memRead && (id_ex_rd != REG_ADDR_W'(X0)) &&
                      ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state variable gets a default first so
        // no path through the case leaves one unassigned (no latches).
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mc_start      = 1'b0;
        state_d       = state_q;
        wd_d          = wd_q;
        timeout_d     = timeout_q;

        unique case (state_q)
            RUN: begin
                if (ex_is_mc) begin
                    // Freeze everything upstream of EX and launch the unit.
                    mc_start      = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    wd_d          = '0;
                    state_d       = MC_BUSY;
                end else if (ex_branch_taken) begin
                    // The ID instruction is wrong-path, so its hazard is moot.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    // One bubble: next cycle the load is in MEM and forwards.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            MC_BUSY: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
                wd_d          = wd_q + 8'd1;
                if (mc_done) begin
                    ex_mem_bubble = 1'b0;
                    state_d       = RUN;
                end else if (wd_q == WD_LAST) begin
                    // Abort: let whatever EX holds through and flag the error.
                    ex_mem_bubble = 1'b0;
                    timeout_d     = 1'b1;
                    state_d       = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign busy       = (state_q == MC_BUSY);
    assign mc_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_act;

    assign stall_act = (state_q == RUN) && !ex_is_mc && !ex_branch_taken && load_use;

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_act),
        .flush_i           (if_id_flush),
        .mc_i              (busy),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
        .perf_mc_cycles    (perf_mc_cycles)
    );
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
    assign perf_mc_cycles    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Testbench for pipeline_hazard_controller (MC_TIMEOUT = 8).
// Output vector compared each cycle (MSB first):
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//   ex_mem_bubble, mc_start, busy, mc_timeout
module tb_pipeline_hazard_controller;

    localparam int RW  = 5;
    localparam int TMO = 8;
    localparam int CW  = 32;

    typedef struct packed {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [RW-1:0] rd;
        logic          mr;
        logic          mc;
        logic          br;
        logic          done;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    // Expected-output shorthands (timeout bit 0).
    localparam logic [8:0] E_DEF   = 9'b11_0_1_0_0_0_0_0;
    localparam logic [8:0] E_STALL = 9'b00_0_1_1_0_0_0_0;
    localparam logic [8:0] E_FLUSH = 9'b11_1_1_1_0_0_0_0;
    localparam logic [8:0] E_MCST  = 9'b00_0_0_0_1_1_0_0;
    localparam logic [8:0] E_BUSY  = 9'b00_0_0_0_1_0_1_0;
    localparam logic [8:0] E_REL   = 9'b00_0_0_0_0_0_1_0;

    logic clk = 1'b0;
    logic rst_n;
    logic [RW-1:0] id_rs1, id_rs2, id_ex_rd;
    logic id_uses_rs1, id_uses_rs2, id_ex_memRead, ex_is_mc, ex_branch_taken, mc_done;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic ex_mem_bubble, mc_start, mc_timeout, busy;
    logic [CW-1:0] perf_stall_cycles, perf_flushes, perf_mc_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: are we waiting on the unit, how many busy
    // cycles have elapsed, and has the watchdog ever fired.
    bit m_busy;
    int m_elapsed;
    bit m_to;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_ADDR_W (RW),
        .MC_TIMEOUT (TMO),
        .CNT_W      (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .id_ex_rd          (id_ex_rd),
        .id_ex_memRead     (id_ex_memRead),
        .ex_is_mc          (ex_is_mc),
        .ex_branch_taken   (ex_branch_taken),
        .mc_done           (mc_done),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_write       (id_ex_write),
        .id_ex_bubble      (id_ex_bubble),
        .ex_mem_bubble     (ex_mem_bubble),
        .mc_start          (mc_start),
        .mc_timeout        (mc_timeout),
        .busy              (busy),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
        .perf_mc_cycles    (perf_mc_cycles)
    );

    function automatic logic [8:0] actual();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                ex_mem_bubble, mc_start, busy, mc_timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act[8:0], exp[8:0], $time);
        end
    endtask

    // True when the ID instruction reads a register a load in EX is still producing.
    function automatic bit depends(input in_t v);
        if (!v.mr || v.rd == 0) return 1'b0;
        return (v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd);
    endfunction

    function automatic logic [8:0] model_out(input in_t v);
        logic [8:0] e;
        if (m_busy) begin
            // This cycle is busy cycle number m_elapsed+1; the last allowed is TMO.
            e = ((v.done) || (m_elapsed + 1 == TMO)) ? E_REL : E_BUSY;
        end else if (v.mc) e = E_MCST;
        else if (v.br)     e = E_FLUSH;
        else if (depends(v)) e = E_STALL;
        else               e = E_DEF;
        e[0] = m_to;
        return e;
    endfunction

    function automatic void model_step(input in_t v);
        if (!m_busy) begin
            if (v.mc) begin
                m_busy    = 1'b1;
                m_elapsed = 0;
            end
        end else begin
            m_elapsed++;
            if (v.done) m_busy = 1'b0;
            else if (m_elapsed == TMO) begin
                m_busy = 1'b0;
                m_to   = 1'b1;
            end
        end
    endfunction

    function automatic void model_reset();
        m_busy    = 1'b0;
        m_elapsed = 0;
        m_to      = 1'b0;
    endfunction

    task automatic drive(input in_t v);
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        id_ex_rd        = v.rd;
        id_ex_memRead   = v.mr;
        ex_is_mc        = v.mc;
        ex_branch_taken = v.br;
        mc_done         = v.done;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic run_cycle(input in_t v, input string name,
                             input bit has_exp, input logic [8:0] exp);
        drive(v);
        @(negedge clk);
        check(name, 32'(actual()), 32'(model_out(v)));
        if (has_exp) check({name, "_tbl"}, 32'(actual()), 32'(exp));
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit mr, input bit mc, input bit br,
                               input bit done);
        in_t v;
        v.rs1 = RW'(rs1); v.rs2 = RW'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = RW'(rd); v.mr = mr; v.mc = mc; v.br = br; v.done = done;
        return v;
    endfunction

    vec_t tbl[10];
    in_t  idle;
    in_t  lu;

    initial begin
        // RUN-state vectors with hand-derived expectations.
        tbl[0] = '{mk(1, 2, 1, 1, 3, 1, 0, 0, 0), E_DEF};    // no dependency
        tbl[1] = '{mk(5, 2, 1, 1, 5, 1, 0, 0, 0), E_STALL};  // rs1 load-use
        tbl[2] = '{mk(5, 2, 1, 1, 5, 0, 0, 0, 0), E_DEF};    // next cycle: defaults
        tbl[3] = '{mk(0, 0, 1, 1, 0, 1, 0, 0, 0), E_DEF};    // load into x0
        tbl[4] = '{mk(1, 7, 1, 0, 7, 1, 0, 0, 0), E_DEF};    // rs2 matches but unused
        tbl[5] = '{mk(1, 7, 1, 1, 7, 1, 0, 0, 0), E_STALL};  // rs2 load-use
        tbl[6] = '{mk(9, 2, 1, 1, 9, 1, 0, 1, 0), E_FLUSH};  // branch beats load-use
        tbl[7] = '{mk(3, 4, 0, 0, 3, 0, 0, 1, 0), E_FLUSH};  // branch alone
        tbl[8] = '{mk(6, 6, 0, 0, 6, 1, 0, 0, 1), E_DEF};    // stray mc_done in RUN
        tbl[9] = '{mk(31, 31, 1, 1, 31, 1, 0, 0, 0), E_STALL}; // top register

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu   = mk(4, 0, 1, 0, 4, 1, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        drive(idle);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_outputs", 32'(actual()), 32'(E_DEF));
        check("reset_perf", perf_stall_cycles | perf_flushes | perf_mc_cycles, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].in, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);
        end

        // Multi-cycle op; branch and load-use present while busy must be ignored.
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "mc_start", 1'b1, E_MCST);
        run_cycle(mk(4, 0, 1, 0, 4, 1, 1, 1, 0), "mc_busy1", 1'b1, E_BUSY);
        run_cycle(mk(4, 0, 1, 0, 4, 1, 1, 0, 0), "mc_busy2", 1'b1, E_BUSY);
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "mc_busy3", 1'b1, E_BUSY);
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 1), "mc_done",  1'b1, E_REL);
        run_cycle(idle, "mc_after", 1'b1, E_DEF);

        // Watchdog: no mc_done, release in the 8th busy cycle, flag sticks.
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "wd_start", 1'b1, E_MCST);
        for (int i = 1; i < TMO; i++)
            run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), $sformatf("wd_busy%0d", i), 1'b1, E_BUSY);
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "wd_release", 1'b1, E_REL);
        run_cycle(idle, "wd_sticky", 1'b1, E_DEF | 9'b1);
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "wd_sticky_mc", 1'b1, E_MCST | 9'b1);
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 1), "wd_sticky_done", 1'b1, E_REL | 9'b1);
        run_cycle(lu, "wd_sticky_lu", 1'b1, E_STALL | 9'b1);
        do_reset();
        check("wd_cleared_by_reset", 32'(actual()), 32'(E_DEF));

        // mc_done on the final watchdog cycle counts as completion, no flag.
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "tie_start", 1'b1, E_MCST);
        for (int i = 1; i < TMO; i++)
            run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), $sformatf("tie_busy%0d", i), 1'b1, E_BUSY);
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 1), "tie_done", 1'b1, E_REL);
        run_cycle(idle, "tie_no_flag", 1'b1, E_DEF);

        // Async reset between clock edges while busy.
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "ar_start", 1'b1, E_MCST);
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "ar_busy", 1'b1, E_BUSY);
        #2;
        rst_n = 1'b0;
        drive(idle);
        model_reset();
        #1;
        check("ar_immediate_run", 32'(actual()), 32'(E_DEF));
        check("ar_perf_cleared", perf_stall_cycles | perf_flushes | perf_mc_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(idle, "ar_no_restart", 1'b1, E_DEF);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_t v;
            v.rs1  = RW'($urandom_range(0, 3));
            v.rs2  = RW'($urandom_range(0, 3));
            v.u1   = 1'($urandom);
            v.u2   = 1'($urandom);
            v.rd   = RW'($urandom_range(0, 3));
            v.mr   = 1'($urandom);
            v.mc   = ($urandom_range(0, 7) == 0);
            v.br   = ($urandom_range(0, 3) == 0);
            v.done = ($urandom_range(0, 4) == 0);
            run_cycle(v, $sformatf("rand%0d", i), 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
